// File: rtl/pipe_delay_line.sv
// pipe_delay_line: DEPTH-stage valid/ready register chain with
// bubble compression, synchronous flush and registered occupancy.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   clr                synchronous flush of every stage
//   in_valid/in_ready  upstream handshake, in_data payload
//   out_valid/out_ready downstream handshake, out_data payload
//   occupancy          number of valid stages after the last edge
module pipe_delay_line #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 3,
  parameter logic [DATA_WIDTH-1:0] RST_VALUE = '0,
  parameter int CNT_WIDTH = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  occupancy
);

  logic [DEPTH-1:0]      v;
  logic [DEPTH-1:0]      v_nxt;
  logic [DEPTH-1:0]      v_src;
  logic [DEPTH-1:0]      r;
  logic [DEPTH-1:0]      ld;
  logic [DATA_WIDTH-1:0] d     [DEPTH];
  logic [DATA_WIDTH-1:0] d_src [DEPTH];
  logic [CNT_WIDTH-1:0]  cnt_nxt;

  // r[i] = out_ready | any empty stage at or after i;
  // an accumulator keeps the ripple free of self-reference.
  always_comb begin : ready_chain
    logic acc;
    r   = '0;
    acc = out_ready;
    for (int i = DEPTH-1; i >= 0; i--) begin
      acc  = acc | ~v[i];
      r[i] = acc;
    end
  end

  always_comb begin
    v_src    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      d_src[i] = RST_VALUE;
    end
    v_src[0] = in_valid;
    d_src[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      v_src[i] = v[i-1];
      d_src[i] = d[i-1];
    end
  end

  // data only moves with a valid item behind it
  assign ld = r & v_src;

  always_comb begin
    if (clr) begin
      v_nxt = '0;
    end else begin
      v_nxt = (r & v_src) | (~r & v);
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + CNT_WIDTH'(v_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v         <= '0;
      occupancy <= '0;
    end else begin
      v         <= v_nxt;
      occupancy <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= RST_VALUE;
      end
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= RST_VALUE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ld[i]) begin
          d[i] <= d_src[i];
        end
      end
    end
  end

  assign in_ready  = r[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_pipe_delay_line.sv
// tb_pipe_delay_line: directed and randomized checks of
// pipe_delay_line at several depths against a queue model.
module tb_pipe_delay_line;

  localparam logic [15:0] RV = 16'hDEAD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_data = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic        ir3, ov3;
  logic [15:0] od3;
  logic [1:0]  oc3;
  logic        ir4, ov4;
  logic [15:0] od4;
  logic [2:0]  oc4;

  logic        ir_r [3];
  logic        ov_r [3];
  logic [15:0] od_r [3];
  logic [0:0]  oc1;
  logic [1:0]  oc2;
  logic [2:0]  oc5;
  int          occ_r [3];

  always_comb begin
    occ_r[0] = int'(oc1);
    occ_r[1] = int'(oc2);
    occ_r[2] = int'(oc5);
  end

  pipe_delay_line #(.DATA_WIDTH(16), .DEPTH(3), .RST_VALUE(RV)) u3 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(ir3), .in_data(in_data),
    .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
    .occupancy(oc3));

  pipe_delay_line #(.DATA_WIDTH(16), .DEPTH(4), .RST_VALUE(RV)) u4 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
    .occupancy(oc4));

  pipe_delay_line #(.DATA_WIDTH(16), .DEPTH(1), .RST_VALUE(RV)) u_r1 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(ir_r[0]), .in_data(in_data),
    .out_valid(ov_r[0]), .out_ready(out_ready), .out_data(od_r[0]),
    .occupancy(oc1));

  pipe_delay_line #(.DATA_WIDTH(16), .DEPTH(2), .RST_VALUE(RV)) u_r2 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(ir_r[1]), .in_data(in_data),
    .out_valid(ov_r[1]), .out_ready(out_ready), .out_data(od_r[1]),
    .occupancy(oc2));

  pipe_delay_line #(.DATA_WIDTH(16), .DEPTH(5), .RST_VALUE(RV)) u_r5 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(ir_r[2]), .in_data(in_data),
    .out_valid(ov_r[2]), .out_ready(out_ready), .out_data(od_r[2]),
    .occupancy(oc5));

  // reference model: ordered items with the edge they were accepted on
  int          dep [3] = '{1, 2, 5};
  logic [15:0] mq_d [3][$];
  int          mq_t [3][$];
  int          edge_n;

  // the oldest item never waits on anything ahead of it, so it
  // reaches the output exactly DEPTH-1 edges after acceptance
  function automatic logic m_valid(int k, int e);
    if (mq_d[k].size() == 0) return 1'b0;
    return (e - mq_t[k][0]) >= dep[k] - 1;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL rst_ov got=%0h exp=0", ov3); end
    checks++; if (od3 !== RV) begin failures++; $display("FAIL rst_od got=%0h exp=%0h", od3, RV); end
    checks++; if (oc3 !== 2'd0) begin failures++; $display("FAIL rst_occ got=%0d exp=0", oc3); end
    checks++; if (ir3 !== 1'b1) begin failures++; $display("FAIL rst_ir got=%0h exp=1", ir3); end
    in_valid = 1'b1; in_data = 16'h0101;
    step();
    in_data = 16'h0202;
    step();
    in_valid = 1'b0;
    step();
    checks++; if (oc3 !== 2'd2) begin failures++; $display("FAIL pre_rst_occ got=%0d exp=2", oc3); end
    checks++; if (ov3 !== 1'b1 || od3 !== 16'h0101) begin failures++; $display("FAIL pre_rst_out got=%0h/%0h exp=1/0101", ov3, od3); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL async_rst_ov got=%0h exp=0", ov3); end
    checks++; if (od3 !== RV) begin failures++; $display("FAIL async_rst_od got=%0h exp=%0h", od3, RV); end
    checks++; if (oc3 !== 2'd0) begin failures++; $display("FAIL async_rst_occ got=%0d exp=0", oc3); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (ir3 !== 1'b1) begin failures++; $display("FAIL post_rst_ir got=%0h exp=1", ir3); end
  endtask

  task automatic test_streaming();
    int n_in, n_out;
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      in_valid = (k <= 8);
      in_data  = 16'(k);
      #1;
      if (k <= 8) begin
        checks++; if (ir3 !== 1'b1) begin failures++; $display("FAIL stream_ir k=%0d got=%0h exp=1", k, ir3); end
      end
      step();
      n_in  = (k < 8) ? k : 8;
      n_out = (k - 3 < 0) ? 0 : ((k - 3 > 8) ? 8 : k - 3);
      checks++; if (oc3 !== 2'(n_in - n_out)) begin failures++; $display("FAIL stream_occ k=%0d got=%0d exp=%0d", k, oc3, n_in - n_out); end
      checks++; if (ov3 !== (k >= 3)) begin failures++; $display("FAIL stream_ov k=%0d got=%0h exp=%0h", k, ov3, k >= 3); end
      if (k >= 3) begin
        checks++; if (od3 !== 16'(k - 2)) begin failures++; $display("FAIL stream_od k=%0d got=%0h exp=%0h", k, od3, k - 2); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] got [$];
    logic        acc;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'hA1 + 16'(i);
      #1;
      checks++; if (ir3 !== 1'b1) begin failures++; $display("FAIL bp_fill_ir i=%0d got=%0h exp=1", i, ir3); end
      step();
    end
    in_data = 16'hA4;
    #1;
    checks++; if (ir3 !== 1'b0) begin failures++; $display("FAIL bp_full_ir got=%0h exp=0", ir3); end
    step();
    checks++; if (oc3 !== 2'd3) begin failures++; $display("FAIL bp_occ got=%0d exp=3", oc3); end
    checks++; if (ov3 !== 1'b1 || od3 !== 16'hA1) begin failures++; $display("FAIL bp_head got=%0h/%0h exp=1/a1", ov3, od3); end
    out_ready = 1'b1;
    #1;
    checks++; if (ir3 !== 1'b1) begin failures++; $display("FAIL bp_ripple_ir got=%0h exp=1", ir3); end
    for (int c = 0; c < 12 && got.size() < 4; c++) begin
      if (ov3) got.push_back(od3);
      acc = in_valid & ir3;
      step();
      if (acc) in_valid = 1'b0;
      #1;
    end
    checks++; if (got.size() != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        checks++; if (got[i] !== 16'hA1 + 16'(i)) begin failures++; $display("FAIL bp_order i=%0d got=%0h exp=%0h", i, got[i], 16'hA1 + 16'(i)); end
      end
    end
    step();
    checks++; if (oc3 !== 2'd0) begin failures++; $display("FAIL bp_drain_occ got=%0d exp=0", oc3); end
  endtask

  task automatic test_bubble();
    do_reset();
    in_valid = 1'b1; in_data = 16'h0011;
    step();
    in_valid = 1'b0;
    step();
    step();
    in_valid = 1'b1; in_data = 16'h0022;
    #1;
    checks++; if (ir4 !== 1'b1) begin failures++; $display("FAIL bub_ir got=%0h exp=1", ir4); end
    step();
    in_valid = 1'b0;
    step();
    step();
    checks++; if (oc4 !== 3'd2) begin failures++; $display("FAIL bub_occ got=%0d exp=2", oc4); end
    checks++; if (ov4 !== 1'b1 || od4 !== 16'h0011) begin failures++; $display("FAIL bub_head got=%0h/%0h exp=1/11", ov4, od4); end
    out_ready = 1'b1;
    step();
    checks++; if (ov4 !== 1'b1 || od4 !== 16'h0022) begin failures++; $display("FAIL bub_next got=%0h/%0h exp=1/22", ov4, od4); end
    checks++; if (oc4 !== 3'd1) begin failures++; $display("FAIL bub_occ1 got=%0d exp=1", oc4); end
    step();
    checks++; if (ov4 !== 1'b0 || oc4 !== 3'd0) begin failures++; $display("FAIL bub_empty got=%0h/%0d exp=0/0", ov4, oc4); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'h55 + 16'(i) * 16'h11;
      step();
    end
    checks++; if (oc3 !== 2'd3) begin failures++; $display("FAIL fl_full got=%0d exp=3", oc3); end
    clr = 1'b1; in_valid = 1'b1; in_data = 16'h88; out_ready = 1'b1;
    #1;
    checks++; if (ir3 !== 1'b1) begin failures++; $display("FAIL fl_ir got=%0h exp=1", ir3); end
    step();
    clr = 1'b0; in_valid = 1'b0;
    checks++; if (oc3 !== 2'd0) begin failures++; $display("FAIL fl_occ got=%0d exp=0", oc3); end
    checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL fl_ov got=%0h exp=0", ov3); end
    checks++; if (od3 !== RV) begin failures++; $display("FAIL fl_od got=%0h exp=%0h", od3, RV); end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL fl_leak c=%0d got=%0h/%0h exp=0", c, ov3, od3); end
    end
  endtask

  task automatic test_random();
    logic pre_v [3];
    logic pre_ir [3];
    logic mv;
    do_reset();
    edge_n = 0;
    for (int k = 0; k < 3; k++) begin
      mq_d[k].delete();
      mq_t[k].delete();
    end
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 127) == 0);
      in_data   = 16'($urandom);
      #1;
      for (int k = 0; k < 3; k++) begin
        pre_v[k]  = m_valid(k, edge_n);
        pre_ir[k] = out_ready || (mq_d[k].size() < dep[k]);
        checks++; if (ir_r[k] !== pre_ir[k]) begin failures++; $display("FAIL rnd_ir d=%0d c=%0d got=%0h exp=%0h", dep[k], c, ir_r[k], pre_ir[k]); end
      end
      @(posedge clk);
      edge_n++;
      for (int k = 0; k < 3; k++) begin
        if (clr) begin
          mq_d[k].delete();
          mq_t[k].delete();
        end else begin
          if (pre_v[k] && out_ready) begin
            void'(mq_d[k].pop_front());
            void'(mq_t[k].pop_front());
          end
          if (in_valid && pre_ir[k]) begin
            mq_d[k].push_back(in_data);
            mq_t[k].push_back(edge_n);
          end
        end
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        mv = m_valid(k, edge_n);
        checks++; if (occ_r[k] != mq_d[k].size()) begin failures++; $display("FAIL rnd_occ d=%0d c=%0d got=%0d exp=%0d", dep[k], c, occ_r[k], mq_d[k].size()); end
        checks++; if (ov_r[k] !== mv) begin failures++; $display("FAIL rnd_ov d=%0d c=%0d got=%0h exp=%0h", dep[k], c, ov_r[k], mv); end
        if (mv) begin
          checks++; if (od_r[k] !== mq_d[k][0]) begin failures++; $display("FAIL rnd_od d=%0d c=%0d got=%0h exp=%0h", dep[k], c, od_r[k], mq_d[k][0]); end
        end
      end
    end
    clr = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired: checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
